counter_rr_sched: RTL and testbench

//  Round-robin scheduler that shares one Counter_fsm + counter pair between NUM_REQ requesters.

---
 rtl/counter_rr_sched.sv | 189 ++++++++++++++++++
 tb/tb_counter_rr_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_rr_sched.sv
// -----------------------------------------------------------------------------
// counter_rr_sched
//   Round-robin scheduler sharing one counter FSM + counter datapath between
//   NUM_REQ requesters. One job runs at a time: the scheduler grants a
//   requester, launches the counter FSM with that requester's target value,
//   waits for the FSM's done pulse and then reports completion to the owner.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   req_i       per-requester job request (level, held until ack_o)
//   cnt_val_i   per-requester target, slice k = [k*CNT_WIDTH +: CNT_WIDTH]
//   ack_o       one-cycle pulse: job of requester k accepted
//   done_o      one-cycle pulse: job of requester k finished
//   start_o     one-cycle start strobe to the counter FSM
//   cnt_val_o   target value to the counter FSM (held after start_o)
//   fsm_done_i  done pulse from the counter FSM (honoured only while waiting)
//   busy_o      high whenever a job is in progress
//   owner_o     index of the current / last granted requester
// -----------------------------------------------------------------------------
module counter_rr_sched #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned CNT_WIDTH = 7,
  parameter int unsigned IDX_W     = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ*CNT_WIDTH-1:0]   cnt_val_i,
  output logic [NUM_REQ-1:0]             ack_o,
  output logic [NUM_REQ-1:0]             done_o,
  output logic                           start_o,
  output logic [CNT_WIDTH-1:0]           cnt_val_o,
  input  logic                           fsm_done_i,
  output logic                           busy_o,
  output logic [IDX_W-1:0]               owner_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RELEASE
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;

  logic [NUM_REQ-1:0]     ack_d, done_d;
  logic                   start_d, busy_d;
  logic [CNT_WIDTH-1:0]   val_d;
  logic [IDX_W-1:0]       owner_d;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: rotate the request vector so the pointer position
  // lands on bit 0, take the first set bit, then rotate the offset back.
  // ---------------------------------------------------------------------------
  logic [2*NUM_REQ-1:0]   req_dbl;
  logic [NUM_REQ-1:0]     req_rot;
  logic                   grant_vld;
  int unsigned            grant_off;
  int unsigned            grant_sum;
  logic [IDX_W-1:0]       grant_idx;
  logic [NUM_REQ-1:0]     grant_oh;
  logic [CNT_WIDTH-1:0]   grant_val;

  always_comb begin
    req_dbl   = {req_i, req_i} >> ptr_q;
    req_rot   = req_dbl[NUM_REQ-1:0];
    grant_vld = 1'b0;
    grant_off = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_vld && req_rot[i]) begin
        grant_vld = 1'b1;
        grant_off = i;
      end
    end
    grant_sum = 32'(ptr_q) + grant_off;
    if (grant_sum >= NUM_REQ) begin
      grant_sum = grant_sum - NUM_REQ;
    end
    grant_idx = IDX_W'(grant_sum);
  end

  // Decode of the grant index into a one-hot vector and the granted target.
  always_comb begin
    grant_oh  = '0;
    grant_val = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == IDX_W'(k)) begin
        grant_oh[k] = 1'b1;
        grant_val   = cnt_val_i[k*CNT_WIDTH +: CNT_WIDTH];
      end
    end
  end

  // One-hot of the latched owner, used for the done pulse.
  logic [NUM_REQ-1:0] owner_oh;

  always_comb begin
    owner_oh = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (owner_o == IDX_W'(k)) begin
        owner_oh[k] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic. Every output is registered, so each
  // pulse is computed on the transition into the state it belongs to:
  // ack/start on IDLE->LAUNCH, done on ->RELEASE.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ack_d   = '0;
    done_d  = '0;
    start_d = 1'b0;
    val_d   = cnt_val_o;
    owner_d = owner_o;

    unique case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          state_d = S_LAUNCH;
          owner_d = grant_idx;
          val_d   = grant_val;
          ack_d   = grant_oh;
          // A zero target would make the counter FSM wrap, so no start.
          start_d = (grant_val != '0);
        end
      end

      S_LAUNCH: begin
        if (cnt_val_o != '0) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_RELEASE;
          done_d  = owner_oh;
        end
      end

      S_WAIT: begin
        if (fsm_done_i) begin
          state_d = S_RELEASE;
          done_d  = owner_oh;
        end
      end

      S_RELEASE: begin
        state_d = S_IDLE;
        ptr_d   = (owner_o == IDX_W'(NUM_REQ - 1)) ? '0 : owner_o + 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      ack_o     <= '0;
      done_o    <= '0;
      start_o   <= 1'b0;
      cnt_val_o <= '0;
      busy_o    <= 1'b0;
      owner_o   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ack_o     <= ack_d;
      done_o    <= done_d;
      start_o   <= start_d;
      cnt_val_o <= val_d;
      busy_o    <= busy_d;
      owner_o   <= owner_d;
    end
  end

endmodule

// File: tb/tb_counter_rr_sched.sv
module tb_counter_rr_sched;

  localparam int unsigned NR = 4;
  localparam int unsigned CW = 7;
  localparam int unsigned IW = 2;

  logic               clk;
  logic               rst_n;
  logic [NR-1:0]      req_i;
  logic [NR*CW-1:0]   cnt_val_i;
  logic [NR-1:0]      ack_o;
  logic [NR-1:0]      done_o;
  logic               start_o;
  logic [CW-1:0]      cnt_val_o;
  logic               fsm_done_i;
  logic               busy_o;
  logic [IW-1:0]      owner_o;

  counter_rr_sched #(
    .NUM_REQ   (NR),
    .CNT_WIDTH (CW),
    .IDX_W     (IW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .cnt_val_i  (cnt_val_i),
    .ack_o      (ack_o),
    .done_o     (done_o),
    .start_o    (start_o),
    .cnt_val_o  (cnt_val_o),
    .fsm_done_i (fsm_done_i),
    .busy_o     (busy_o),
    .owner_o    (owner_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: inputs applied before an edge, outputs expected
  // in the cycle after that edge. Outputs packed {ack,done,start,busy,owner,cnt}.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [NR-1:0]    req;
    logic [NR*CW-1:0] cv;
    logic             fd;
    logic [NR-1:0]    ack;
    logic [NR-1:0]    done;
    logic             start;
    logic             busy;
    logic [IW-1:0]    owner;
    logic [CW-1:0]    cnt;
  } vec_t;

  vec_t tbl[21];

  function automatic logic [NR*CW-1:0] pk(input int v3, input int v2, input int v1, input int v0);
    return {CW'(v3), CW'(v2), CW'(v1), CW'(v0)};
  endfunction

  function automatic vec_t mk(input logic [NR-1:0] rq, input logic [NR*CW-1:0] cv, input logic fd,
                              input logic [NR-1:0] a, input logic [NR-1:0] d, input logic s,
                              input logic b, input logic [IW-1:0] o, input logic [CW-1:0] v);
    vec_t r;
    r.req = rq; r.cv = cv; r.fd = fd;
    r.ack = a; r.done = d; r.start = s; r.busy = b; r.owner = o; r.cnt = v;
    return r;
  endfunction

  task automatic do_reset();
    rst_n      = 1'b0;
    req_i      = '0;
    fsm_done_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", {ack_o, done_o, start_o, busy_o, owner_o, cnt_val_o}, '0);
    rst_n = 1'b1;
  endtask

  // Wait for the grant of requester g and run its job to completion.
  task automatic serve(input int g, input logic [CW-1:0] v, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack_o == '0 && n < 20);
    chk({nm, "_ack"}, ack_o, NR'(1) << g);
    chk({nm, "_owner"}, owner_o, g);
    chk({nm, "_start_val"}, {start_o, cnt_val_o}, {(v != '0), v});
    req_i[g] = 1'b0;
    if (v != '0) begin
      @(negedge clk);
      fsm_done_i = 1'b1;
      @(negedge clk);
      fsm_done_i = 1'b0;
    end else begin
      @(negedge clk);
    end
    chk({nm, "_done"}, {ack_o, done_o}, {{NR{1'b0}}, NR'(1) << g});
    @(negedge clk);
    chk({nm, "_idle"}, busy_o, 0);
  endtask

  // Random-phase reference model state (transaction timeline).
  int unsigned      m_ptr;
  int               ack_at, done_at, fd_at, idle_from, chg_at, dly;
  int unsigned      g_srch;
  logic [IW-1:0]    j_g, e_owner, nx_owner;
  logic [CW-1:0]    j_v, e_cnt, nx_cnt;
  logic [NR-1:0]    oh, e_ack, e_done;
  logic             e_start, e_busy, in_wait;
  int               order[5];

  initial begin
    logic [NR*CW-1:0] p5, p3, p46;
    rst_n      = 1'b0;
    req_i      = '0;
    cnt_val_i  = '0;
    fsm_done_i = 1'b0;

    p5  = pk(0, 5, 0, 0);
    p3  = pk(3, 0, 0, 0);
    p46 = pk(4, 0, 0, 6);
    tbl[0]  = mk(4'b0100, p5, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 2, 5);
    tbl[1]  = mk(4'b0000, p5, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2, 5);
    tbl[2]  = mk(4'b0000, p5, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b1, 2, 5);
    tbl[3]  = mk(4'b0000, p5, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2, 5);
    tbl[4]  = mk(4'b0010, p5, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 1, 0);
    tbl[5]  = mk(4'b0000, p5, 1'b0, 4'b0000, 4'b0010, 1'b0, 1'b1, 1, 0);
    tbl[6]  = mk(4'b0000, p5, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1, 0);
    tbl[7]  = mk(4'b1000, p3, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b1, 3, 3);
    tbl[8]  = mk(4'b0000, p3, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 3, 3);
    tbl[9]  = mk(4'b0000, p3, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 3, 3);
    tbl[10] = mk(4'b0000, p3, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b1, 3, 3);
    tbl[11] = mk(4'b0000, p3, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 3, 3);
    tbl[12] = mk(4'b1001, p46, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 0, 6);
    tbl[13] = mk(4'b1000, p46, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 0, 6);
    tbl[14] = mk(4'b1000, p46, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b1, 0, 6);
    tbl[15] = mk(4'b1000, p46, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 0, 6);
    tbl[16] = mk(4'b1000, p46, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b1, 3, 4);
    tbl[17] = mk(4'b0000, p46, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 3, 4);
    tbl[18] = mk(4'b0000, p46, 1'b1, 4'b0000, 4'b1000, 1'b0, 1'b1, 3, 4);
    tbl[19] = mk(4'b0000, p46, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 3, 4);
    tbl[20] = mk(4'b0000, p46, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 3, 4);

    // ---- table-driven: single job, zero value, pointer wrap, stray done ----
    do_reset();
    for (int i = 0; i < 21; i++) begin
      req_i      = tbl[i].req;
      cnt_val_i  = tbl[i].cv;
      fsm_done_i = tbl[i].fd;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {ack_o, done_o, start_o, busy_o, owner_o, cnt_val_o},
          {tbl[i].ack, tbl[i].done, tbl[i].start, tbl[i].busy, tbl[i].owner, tbl[i].cnt});
    end

    // ---- all requesting after reset: order 0,1,2,3,0 ----
    do_reset();
    for (int k = 0; k < NR; k++) cnt_val_i[k*CW +: CW] = CW'(k + 1);
    req_i = 4'b1111;
    order = '{0, 1, 2, 3, 0};
    for (int j = 0; j < 5; j++) begin
      serve(order[j], CW'(order[j] + 1), $sformatf("rr_all%0d", j));
      req_i[order[j]] = 1'b1;
    end
    req_i = '0;

    // ---- late changes during WAIT ----
    cnt_val_i[0 +: CW] = 7;
    req_i[0] = 1'b1;
    @(negedge clk);
    chk("late_launch", {ack_o, start_o, cnt_val_o}, {4'b0001, 1'b1, 7'd7});
    req_i[0] = 1'b0;
    @(negedge clk);
    cnt_val_i[0 +: CW]    = 9;
    cnt_val_i[3*CW +: CW] = 2;
    req_i[3] = 1'b1;
    @(negedge clk);
    chk("late_hold", {ack_o, start_o, busy_o, cnt_val_o}, {4'b0000, 1'b0, 1'b1, 7'd7});
    fsm_done_i = 1'b1;
    @(negedge clk);
    fsm_done_i = 1'b0;
    chk("late_done0", {ack_o, done_o}, {4'b0000, 4'b0001});
    serve(3, 2, "late_req3");

    // ---- reset mid-WAIT ----
    cnt_val_i[2*CW +: CW] = 5;
    req_i = 4'b0100;
    serve(2, 5, "pre_rst");
    cnt_val_i[0 +: CW] = 6;
    req_i = 4'b0001;
    @(negedge clk);
    chk("rst_launch", ack_o, 4'b0001);
    req_i = '0;
    @(negedge clk);
    chk("rst_in_wait", busy_o, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async", {ack_o, done_o, start_o, busy_o, owner_o, cnt_val_o}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fsm_done_i = (i == 0);
      @(negedge clk);
      chk($sformatf("rst_no_done%0d", i), {ack_o, done_o, busy_o}, '0);
    end
    fsm_done_i = 1'b0;
    cnt_val_i[1*CW +: CW] = 3;
    cnt_val_i[3*CW +: CW] = 4;
    req_i = 4'b1010;
    serve(1, 3, "post_rst");
    req_i = '0;

    // ---- randomized traffic against a transaction-timeline model ----
    do_reset();
    m_ptr = 0; ack_at = -10; done_at = -10; fd_at = -10; idle_from = 0; chg_at = -10;
    j_g = '0; j_v = '0; e_owner = '0; e_cnt = '0; nx_owner = '0; nx_cnt = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == chg_at) begin
        e_owner = nx_owner;
        e_cnt   = nx_cnt;
      end
      oh      = NR'(1) << j_g;
      e_ack   = (c == ack_at)  ? oh : '0;
      e_done  = (c == done_at) ? oh : '0;
      e_start = (c == ack_at) && (j_v != '0);
      e_busy  = (c >= ack_at) && (c < idle_from);
      chk($sformatf("rand_c%0d", c), {ack_o, done_o, start_o, busy_o, owner_o, cnt_val_o},
          {e_ack, e_done, e_start, e_busy, e_owner, e_cnt});

      in_wait    = (j_v != '0) && (c > ack_at) && (c < done_at);
      fsm_done_i = (c == fd_at) || (!in_wait && $urandom_range(0, 7) == 0);

      for (int k = 0; k < NR; k++) begin
        if (req_i[k] && c == ack_at && int'(j_g) == k) begin
          req_i[k] = 1'b0;
        end else if (!req_i[k]) begin
          if ($urandom_range(0, 5) == 0) begin
            req_i[k] = 1'b1;
            cnt_val_i[k*CW +: CW] = ($urandom_range(0, 3) == 0) ? '0 : CW'($urandom_range(1, 127));
          end
        end else if ($urandom_range(0, 19) == 0) begin
          req_i[k] = 1'b0;
        end
      end

      if (c >= idle_from && req_i != '0) begin
        g_srch = m_ptr;
        while (!req_i[g_srch]) g_srch = (g_srch + 1) % NR;
        j_g      = IW'(g_srch);
        j_v      = cnt_val_i[g_srch*CW +: CW];
        ack_at   = c + 1;
        chg_at   = c + 1;
        nx_owner = j_g;
        nx_cnt   = j_v;
        if (j_v == '0) begin
          fd_at   = -10;
          done_at = c + 2;
        end else begin
          dly     = int'($urandom_range(1, 4));
          fd_at   = c + 1 + dly;
          done_at = c + 2 + dly;
        end
        idle_from = done_at + 1;
        m_ptr     = (g_srch + 1) % NR;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
